// File: rtl/tow_pkg.sv
// tow_pkg: shared state, winner and 7-segment encodings for the tug-of-war match logic.
package tow_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, PLAY, HOLD, DONE} state_e;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L = 2'b10;
  localparam logic [1:0] WIN_R = 2'b01;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: round inputs, start button and match/score outputs of the match controller.
interface match_controller_if #(parameter int SCORE_W = 3);
  logic start;
  logic L_round;
  logic R_round;
  logic field_reset;
  logic play_en;
  logic [SCORE_W-1:0] L_score;
  logic [SCORE_W-1:0] R_score;
  logic match_done;
  logic [1:0] match_winner;
  logic [6:0] HEX_L;
  logic [6:0] HEX_R;
  modport master (
    output start, L_round, R_round,
    input field_reset, play_en, L_score, R_score, match_done, match_winner, HEX_L, HEX_R
  );
  modport slave (
    input start, L_round, R_round,
    output field_reset, play_en, L_score, R_score, match_done, match_winner, HEX_L, HEX_R
  );
endinterface

// File: rtl/match_controller_seg7_digit.sv
// seg7_digit: active-low g..a decoder for one score digit; values above 9 blank the digit.
module seg7_digit
  import tow_pkg::*;
#(parameter int W = 3) (
  input  logic [W-1:0] val_i,
  output logic [6:0]   seg_o
);
  always_comb begin
    case (32'(val_i))
      0: seg_o = SEG_0;
      1: seg_o = SEG_1;
      2: seg_o = SEG_2;
      3: seg_o = SEG_3;
      4: seg_o = SEG_4;
      5: seg_o = SEG_5;
      6: seg_o = SEG_6;
      7: seg_o = SEG_7;
      8: seg_o = SEG_8;
      9: seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/match_controller.sv
// match_controller: best-of-N round sequencer with pause, field clearing, winner and HEX score display.
module match_controller
  import tow_pkg::*;
#(
  parameter int WIN_ROUNDS = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W = 3
) (
  input logic clk,
  input logic reset,
  match_controller_if.slave bus
);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  state_e state_q, state_d;
  logic [SCORE_W-1:0] l_q, l_d, r_q, r_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] win_q, win_d;
  logic start_q;
  logic start_edge, one_l, one_r;
  logic [SCORE_W-1:0] l_inc, r_inc;
  assign start_edge = bus.start & ~start_q;
  assign one_l = bus.L_round & ~bus.R_round;
  assign one_r = bus.R_round & ~bus.L_round;
  assign l_inc = l_q + 1'b1;
  assign r_inc = r_q + 1'b1;
  // start_q resets high so a button held through reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      l_q <= '0;
      r_q <= '0;
      timer_q <= '0;
      win_q <= WIN_NONE;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      l_q <= l_d;
      r_q <= r_d;
      timer_q <= timer_d;
      win_q <= win_d;
      start_q <= bus.start;
    end
  end
  always_comb begin
    state_d = state_q;
    l_d = l_q;
    r_d = r_q;
    timer_d = timer_q;
    win_d = win_q;
    if (start_edge && state_q != CLEAR) begin
      state_d = CLEAR;
      l_d = '0;
      r_d = '0;
      win_d = WIN_NONE;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        CLEAR: state_d = PLAY;
        PLAY: begin
          if (one_l) begin
            l_d = l_inc;
            state_d = (l_inc == SCORE_W'(WIN_ROUNDS)) ? DONE : HOLD;
            win_d = (l_inc == SCORE_W'(WIN_ROUNDS)) ? WIN_L : win_q;
            timer_d = TW'(HOLD_CYCLES - 1);
          end else if (one_r) begin
            r_d = r_inc;
            state_d = (r_inc == SCORE_W'(WIN_ROUNDS)) ? DONE : HOLD;
            win_d = (r_inc == SCORE_W'(WIN_ROUNDS)) ? WIN_R : win_q;
            timer_d = TW'(HOLD_CYCLES - 1);
          end
        end
        HOLD: begin
          timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
          state_d = (timer_q == '0) ? CLEAR : HOLD;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    bus.field_reset = (state_q == IDLE) || (state_q == CLEAR);
    bus.play_en = (state_q == PLAY);
    bus.match_done = (state_q == DONE);
    bus.match_winner = win_q;
    bus.L_score = l_q;
    bus.R_score = r_q;
  end
  seg7_digit #(.W(SCORE_W)) u_hex_l (.val_i(l_q), .seg_o(bus.HEX_L));
  seg7_digit #(.W(SCORE_W)) u_hex_r (.val_i(r_q), .seg_o(bus.HEX_R));
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed checks of match sequencing, pause timing, abort and async reset.
module tb_match_controller;
  logic clk;
  logic reset;
  int checks = 0;
  int failures = 0;
  match_controller_if #(.SCORE_W(3)) bus();
  match_controller #(.WIN_ROUNDS(3), .HOLD_CYCLES(4), .SCORE_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic fr, input logic pe, input logic md,
                      input logic [2:0] ls, input logic [2:0] rs, input logic [1:0] w);
    check({tag, ".field_reset"}, 32'(bus.field_reset), 32'(fr));
    check({tag, ".play_en"}, 32'(bus.play_en), 32'(pe));
    check({tag, ".match_done"}, 32'(bus.match_done), 32'(md));
    check({tag, ".L_score"}, 32'(bus.L_score), 32'(ls));
    check({tag, ".R_score"}, 32'(bus.R_score), 32'(rs));
    check({tag, ".winner"}, 32'(bus.match_winner), 32'(w));
  endtask
  task automatic start_pulse();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b1;
    bus.L_round = 1'b0;
    bus.R_round = 1'b0;
    #2;
    outs("rst_async", 1, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    check("rst.HEX_L", 32'(bus.HEX_L), 32'(7'b1000000));
    check("rst.HEX_R", 32'(bus.HEX_R), 32'(7'b1000000));
    reset = 1'b0;
    tick();
    tick();
    outs("idle_held_start", 1, 0, 0, 0, 0, 2'b00);
    start_pulse();
    outs("clear1", 1, 0, 0, 0, 0, 2'b00);
    tick();
    outs("play1", 0, 1, 0, 0, 0, 2'b00);
    // left wins round 1; level held through the pause
    bus.L_round = 1'b1;
    tick();
    outs("hold_e0", 0, 0, 0, 1, 0, 2'b00);
    check("hold.HEX_L", 32'(bus.HEX_L), 32'(7'b1111001));
    for (int i = 1; i < 4; i++) begin
      tick();
      outs($sformatf("hold_e%0d", i), 0, 0, 0, 1, 0, 2'b00);
    end
    tick();
    outs("clear_after_hold", 1, 0, 0, 1, 0, 2'b00);
    bus.L_round = 1'b0;
    tick();
    outs("play_after_hold", 0, 1, 0, 1, 0, 2'b00);
    bus.L_round = 1'b1;
    bus.R_round = 1'b1;
    tick();
    outs("both_high", 0, 1, 0, 1, 0, 2'b00);
    tick();
    outs("both_high2", 0, 1, 0, 1, 0, 2'b00);
    bus.L_round = 1'b0;
    bus.R_round = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      bus.R_round = 1'b1;
      tick();
      bus.R_round = 1'b0;
      if (n < 3) begin
        outs($sformatf("r_win%0d", n), 0, 0, 0, 1, 3'(n), 2'b00);
        repeat (5) tick();
        check($sformatf("r_replay%0d", n), 32'(bus.play_en), 32'd1);
      end
    end
    outs("done", 0, 0, 1, 1, 3, 2'b01);
    check("done.HEX_R", 32'(bus.HEX_R), 32'(7'b0110000));
    bus.R_round = 1'b1;
    tick();
    bus.R_round = 1'b0;
    bus.L_round = 1'b1;
    tick();
    bus.L_round = 1'b0;
    tick();
    outs("done_frozen", 0, 0, 1, 1, 3, 2'b01);
    start_pulse();
    outs("restart_clear", 1, 0, 0, 0, 0, 2'b00);
    check("restart.HEX_R", 32'(bus.HEX_R), 32'(7'b1000000));
    tick();
    outs("restart_play", 0, 1, 0, 0, 0, 2'b00);
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.L_round = 1'b1;
    tick();
    bus.L_round = 1'b0;
    outs("abort_vs_round", 1, 0, 0, 0, 0, 2'b00);
    tick();
    outs("abort_play", 0, 1, 0, 0, 0, 2'b00);
    bus.L_round = 1'b1;
    tick();
    bus.L_round = 1'b0;
    outs("abort_hold_pre", 0, 0, 0, 1, 0, 2'b00);
    start_pulse();
    outs("abort_hold_clear", 1, 0, 0, 0, 0, 2'b00);
    tick();
    outs("abort_hold_play", 0, 1, 0, 0, 0, 2'b00);
    bus.R_round = 1'b1;
    tick();
    bus.R_round = 1'b0;
    tick();
    outs("pre_async", 0, 0, 0, 0, 1, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    outs("async_reset", 1, 0, 0, 0, 0, 2'b00);
    #3;
    reset = 1'b0;
    tick();
    outs("post_async_idle", 1, 0, 0, 0, 0, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a best-of-N tug-of-war match on top of the playfield and round-winner logic.
- Starts matches on a start-button edge and holds the playfield in reset while idle.
- Counts round wins per player, inserts a timed pause after each round, then clears the field for the next round.
- Declares the match winner and drives two score digits on the HEX displays.

Parameters:
WIN_ROUNDS, 3, round wins needed to take the match (legal 1..7)
HOLD_CYCLES, 8, pause length in clk cycles after a round is won (legal >= 1)
SCORE_W, 3, score counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  start/restart button level; only its rising edge acts
L_round  input  1  level: left player (player2) has won the current round; held until field_reset
R_round  input  1  level: right player (player1) has won the current round; held until field_reset
field_reset  output  1  clears playfield and round-winner logic
play_en  output  1  playfield may accept presses
L_score  output  SCORE_W  left round wins
R_score  output  SCORE_W  right round wins
match_done  output  1  match finished
match_winner  output  2  00 none, 10 left, 01 right
HEX_L  output  7  active-low 7-seg digit of L_score
HEX_R  output  7  active-low 7-seg digit of R_score

Behaviour:
- Reset (async, active-high, no clock edge needed): state IDLE, scores 0, timer 0, winner 00, start_q=1.
  - start_q=1 means start held through reset release does not count as an edge.
- Start edge: start_edge = start & ~start_q; start_q registers start every cycle.
- All outputs are Moore, decoded from registered state and registers.
- IDLE: field_reset=1, play_en=0, match_done=0. start_edge -> CLEAR; clear scores and winner on the same edge.
- CLEAR: exactly 1 cycle; field_reset=1, play_en=0. Always -> PLAY.
- PLAY: field_reset=0, play_en=1.
  - Exactly one of L_round/R_round high: increment that score on the same edge.
  - If the new score == WIN_ROUNDS -> DONE and set winner (10 or 01); else -> HOLD with timer loaded to HOLD_CYCLES-1.
  - Both high: illegal; no score change, stay PLAY.
  - Neither high: stay PLAY.
- HOLD: field_reset=0, play_en=0; round inputs ignored. Timer decrements each cycle; at timer==0 -> CLEAR.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- DONE: match_done=1, play_en=0, field_reset=0, scores and winner frozen; round inputs ignored.
  - start_edge -> CLEAR; clear scores and winner on the same edge.
- Start edge in PLAY or HOLD aborts the match: clear scores and winner, -> CLEAR.
  - start_edge has priority over a simultaneous round input: no score is taken.
- Latency:
  - Round input sampled at edge E -> score visible after E.
  - play_en=0 for HOLD_CYCLES cycles, then field_reset=1 for 1 cycle, then play_en=1 at E+HOLD_CYCLES+1.
- Scores never exceed WIN_ROUNDS; no wrap.
- HEX decode, active-low, segment order g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.

Decomposition:
- Package tow_pkg holds:
  - state enum {IDLE, CLEAR, PLAY, HOLD, DONE}
  - winner codes WIN_NONE/WIN_L/WIN_R
  - 7-seg constants SEG_0..SEG_9
- Sub-module seg7_digit: combinational score-to-segment decoder, instantiated twice (HEX_L, HEX_R).

Test Plan:
1. Reset asserted with start=1, then released -> field_reset=1, scores 0, HEX_L=HEX_R=1000000, state stays IDLE. Drop start, then raise it -> 1 cycle field_reset=1, then play_en=1.
2. HOLD_CYCLES=4, L_round=1 for 1 cycle in PLAY -> L_score=1, HEX_L=1111001 next cycle; play_en=0 for 4 cycles; field_reset=1 for 1 cycle; play_en=1.
3. WIN_ROUNDS=3, three R_round wins -> R_score=3, HEX_R=0110000, match_done=1, match_winner=01. Further R_round/L_round pulses change nothing.
4. L_round=R_round=1 in PLAY -> scores unchanged, play_en stays 1, state stays PLAY.
5. Start edge coincident with L_round in PLAY, and separately start edge during HOLD -> scores return to 0, CLEAR for 1 cycle, then PLAY.
6. reset pulsed between clock edges during HOLD -> outputs return to reset values immediately, without waiting for a clk edge.
